// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload and a rising-edge tick.
// Optional macro DUTY50_EN adds a negedge flop so odd divisors produce an exact 50% duty cycle.
module freq_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_busy,
  output logic             cfg_err
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] n_act;
  logic [DIV_W-1:0] pend_val;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] n_nx;
  logic [DIV_W-1:0] half_nx;
  logic             wrap;
  logic             legal;
  logic             clk_pos;

  // The high/low split is derived from the divisor that owns the coming period,
  // so a freshly applied divisor shapes its very first cycle.
  always_comb begin
    last    = n_act - ONE;
    wrap    = (cnt == last);
    cnt_nx  = wrap ? '0 : cnt + ONE;
    n_nx    = (wrap && div_busy) ? pend_val : n_act;
    half_nx = n_nx >> 1;
    legal   = (div_val >= TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= RST_CNT;
      n_act   <= RST_DIV;
      clk_pos <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_nx;
      n_act   <= n_nx;
      clk_pos <= (cnt_nx < half_nx);
      tick    <= (cnt_nx == '0);
    end else begin
      tick    <= 1'b0;
    end
  end

  // A load landing on an applying wrap refills the pending slot, so busy stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= RST_DIV;
      div_busy <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= div_load && !legal;
      if (div_load && legal) begin
        pend_val <= div_val;
        div_busy <= 1'b1;
      end else if (en && wrap && div_busy) begin
        div_busy <= 1'b0;
      end
    end
  end

`ifdef DUTY50_EN
  logic clk_neg;

  // Half a cycle of extension on odd divisors balances the extra low cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_neg <= 1'b0;
    end else begin
      clk_neg <= n_act[0] & clk_pos;
    end
  end

  assign clk_out = clk_pos | clk_neg;
`else
  assign clk_out = clk_pos;
`endif

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed self-checking bench for freq_div_prog (default DIV_W=8, DEFAULT_DIV=4).
// Expected odd-divisor duty depends on whether DUTY50_EN is defined for the build.
module tb_freq_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic       div_busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  freq_div_prog #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_busy (div_busy),
    .cfg_err  (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reset clk_out: got %b expected 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset tick: got %b expected 0", tick); end
    checks++; if (div_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset div_busy: got %b expected 0", div_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset cfg_err: got %b expected 0", cfg_err); end
    en = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0 || tick !== 1'b0) begin errors++; $display("[TB] FAIL reset held: got clk_out=%b tick=%b expected 0 0", clk_out, tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_default_pattern();
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (clk_out !== ((i % 4) < 2)) begin errors++; $display("[TB] FAIL default clk_out cyc %0d: got %b expected %b", i, clk_out, ((i % 4) < 2)); end
      checks++; if (tick !== ((i % 4) == 0)) begin errors++; $display("[TB] FAIL default tick cyc %0d: got %b expected %b", i, tick, ((i % 4) == 0)); end
    end
  endtask

  task automatic test_load_mid_period();
    step();
    checks++; if (clk_out !== 1'b1 || tick !== 1'b1) begin errors++; $display("[TB] FAIL mid cnt0: got clk_out=%b tick=%b expected 1 1", clk_out, tick); end
    step();
    checks++; if (clk_out !== 1'b1 || tick !== 1'b0) begin errors++; $display("[TB] FAIL mid cnt1: got clk_out=%b tick=%b expected 1 0", clk_out, tick); end
    div_load = 1'b1;
    div_val  = 8'd5;
    step();
    div_load = 1'b0;
    checks++; if (clk_out !== 1'b0 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid cnt2: got clk_out=%b busy=%b expected 0 1", clk_out, div_busy); end
    step();
    checks++; if (clk_out !== 1'b0 || div_busy !== 1'b1 || tick !== 1'b0) begin errors++; $display("[TB] FAIL mid cnt3: got clk_out=%b busy=%b tick=%b expected 0 1 0", clk_out, div_busy, tick); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (clk_out !== ((i % 5) < 2)) begin errors++; $display("[TB] FAIL n5 clk_out cyc %0d: got %b expected %b", i, clk_out, ((i % 5) < 2)); end
      checks++; if (tick !== ((i % 5) == 0)) begin errors++; $display("[TB] FAIL n5 tick cyc %0d: got %b expected %b", i, tick, ((i % 5) == 0)); end
      checks++; if (div_busy !== 1'b0) begin errors++; $display("[TB] FAIL n5 busy cyc %0d: got %b expected 0", i, div_busy); end
    end
  endtask

  task automatic test_load_on_wrap();
    div_load = 1'b1;
    div_val  = 8'd4;
    step();
    div_load = 1'b0;
    checks++; if (clk_out !== 1'b1 || tick !== 1'b1 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL wrapload edge: got clk_out=%b tick=%b busy=%b expected 1 1 1", clk_out, tick, div_busy); end
    for (int i = 1; i < 5; i++) begin
      step();
      checks++; if (clk_out !== (i < 2) || tick !== 1'b0 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL wrapload old period cyc %0d: got clk_out=%b tick=%b busy=%b expected %b 0 1", i, clk_out, tick, div_busy, (i < 2)); end
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0) || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL wrapload n4 cyc %0d: got clk_out=%b tick=%b busy=%b expected %b %b 0", i, clk_out, tick, div_busy, ((i % 4) < 2), ((i % 4) == 0)); end
    end
  endtask

  task automatic test_illegal_load();
    div_load = 1'b1;
    div_val  = 8'd1;
    step();
    div_load = 1'b0;
    checks++; if (cfg_err !== 1'b1 || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL load1: got cfg_err=%b busy=%b expected 1 0", cfg_err, div_busy); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL load1 pulse width: got cfg_err=%b expected 0", cfg_err); end
    div_load = 1'b1;
    div_val  = 8'd0;
    step();
    div_load = 1'b0;
    checks++; if (cfg_err !== 1'b1 || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL load0: got cfg_err=%b busy=%b expected 1 0", cfg_err, div_busy); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL load0 pulse width: got cfg_err=%b expected 0", cfg_err); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0) || div_busy !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL illegal n4 cyc %0d: got clk_out=%b tick=%b busy=%b err=%b expected %b %b 0 0", i, clk_out, tick, div_busy, cfg_err, ((i % 4) < 2), ((i % 4) == 0)); end
    end
  endtask

  task automatic test_max_divisor();
    int c;
    div_load = 1'b1;
    div_val  = 8'd255;
    step();
    div_load = 1'b0;
    checks++; if (tick !== 1'b1 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL max load edge: got tick=%b busy=%b expected 1 1", tick, div_busy); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (clk_out !== (i < 2) || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL max pre-apply cyc %0d: got clk_out=%b busy=%b expected %b 1", i, clk_out, div_busy, (i < 2)); end
    end
    for (int i = 0; i < 256; i++) begin
      step();
      c = i % 255;
      checks++; if (clk_out !== (c < 127) || tick !== (c == 0)) begin errors++; $display("[TB] FAIL n255 cyc %0d: got clk_out=%b tick=%b expected %b %b", i, clk_out, tick, (c < 127), (c == 0)); end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    step();
    checks++; if (clk_out !== 1'b1 || tick !== 1'b1) begin errors++; $display("[TB] FAIL en cnt0: got clk_out=%b tick=%b expected 1 1", clk_out, tick); end
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (clk_out !== 1'b1 || tick !== 1'b0) begin errors++; $display("[TB] FAIL en frozen %0d: got clk_out=%b tick=%b expected 1 0", i, clk_out, tick); end
    end
    en = 1'b1;
    step();
    checks++; if (clk_out !== 1'b0 || tick !== 1'b0) begin errors++; $display("[TB] FAIL en resume cnt2: got clk_out=%b tick=%b expected 0 0", clk_out, tick); end
    step();
    checks++; if (clk_out !== 1'b0 || tick !== 1'b0) begin errors++; $display("[TB] FAIL en resume cnt3: got clk_out=%b tick=%b expected 0 0", clk_out, tick); end
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0)) begin errors++; $display("[TB] FAIL en after cyc %0d: got clk_out=%b tick=%b expected %b %b", i, clk_out, tick, ((i % 4) < 2), ((i % 4) == 0)); end
    end
  endtask

  task automatic test_reset_mid_period();
    apply_reset();
    step();
    div_load = 1'b1;
    div_val  = 8'd7;
    step();
    div_val  = 8'd6;
    checks++; if (div_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst first load busy: got %b expected 1", div_busy); end
    step();
    div_load = 1'b0;
    en       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (clk_out !== 1'b0 || tick !== 1'b0 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst disabled hold %0d: got clk_out=%b tick=%b busy=%b expected 0 0 1", i, clk_out, tick, div_busy); end
    end
    en = 1'b1;
    step();
    checks++; if (div_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst cnt3 busy: got %b expected 1", div_busy); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (clk_out !== (i < 3) || tick !== (i == 0) || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst n6 cyc %0d: got clk_out=%b tick=%b busy=%b expected %b %b 0", i, clk_out, tick, div_busy, (i < 3), (i == 0)); end
    end
    div_load = 1'b1;
    div_val  = 8'd3;
    step();
    div_load = 1'b0;
    checks++; if (clk_out !== 1'b1 || tick !== 1'b1 || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst n6 wrap: got clk_out=%b tick=%b busy=%b expected 1 1 1", clk_out, tick, div_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0 || tick !== 1'b0 || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst async: got clk_out=%b tick=%b busy=%b expected 0 0 0", clk_out, tick, div_busy); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0) || div_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst after cyc %0d: got clk_out=%b tick=%b busy=%b expected %b %b 0", i, clk_out, tick, div_busy, ((i % 4) < 2), ((i % 4) == 0)); end
    end
  endtask

  task automatic test_odd_duty();
    logic exp_pos;
    logic exp_neg;
    int   c;
    div_load = 1'b1;
    div_val  = 8'd3;
    step();
    div_load = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (clk_out !== (i < 2) || div_busy !== 1'b1) begin errors++; $display("[TB] FAIL odd pre-apply cyc %0d: got clk_out=%b busy=%b expected %b 1", i, clk_out, div_busy, (i < 2)); end
    end
    for (int i = 0; i < 6; i++) begin
      c = i % 3;
`ifdef DUTY50_EN
      exp_pos = (c <= 1);
`else
      exp_pos = (c == 0);
`endif
      exp_neg = (c == 0);
      step();
      checks++; if (clk_out !== exp_pos || tick !== (c == 0)) begin errors++; $display("[TB] FAIL n3 posphase cyc %0d: got clk_out=%b tick=%b expected %b %b", i, clk_out, tick, exp_pos, (c == 0)); end
      @(negedge clk);
      #1;
      checks++; if (clk_out !== exp_neg) begin errors++; $display("[TB] FAIL n3 negphase cyc %0d: got clk_out=%b expected %b", i, clk_out, exp_neg); end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_load_mid_period();
    test_load_on_wrap();
    test_illegal_load();
    test_max_divisor();
    test_enable();
    test_reset_mid_period();
    test_odd_duty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
